// File: rtl/bitser_if.sv
// rtl/bitser_if.sv - handshake bundle between operand source, bitser and plane consumer
//
// Purpose: carries the parallel-word input stream and the bit-plane output stream.
//   master : producer of words / consumer of planes (memory side + MVU side)
//   slave  : the serializer itself
// Signals:
//   in_valid/in_ready   word handshake
//   in_data  [N*B]      lane i at in_data[i*B +: B]
//   in_prec  [PW]       precision of the word
//   in_sgn              word is two's complement
//   out_valid/out_ready plane handshake
//   out_plane [N]       current bit of every lane
//   out_first/out_last  framing of the word's planes
//   out_msb             plane carries negative weight
interface bitser_if #(
    parameter int N  = 64,
    parameter int B  = 8,
    parameter int PW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [N*B-1:0]  in_data;
    logic [PW-1:0]   in_prec;
    logic            in_sgn;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_plane;
    logic            out_first;
    logic            out_last;
    logic            out_msb;

    modport master (
        output in_valid, in_data, in_prec, in_sgn, out_ready,
        input  in_ready, out_valid, out_plane, out_first, out_last, out_msb
    );

    modport slave (
        input  in_valid, in_data, in_prec, in_sgn, out_ready,
        output in_ready, out_valid, out_plane, out_first, out_last, out_msb
    );
endinterface

// File: rtl/bitser.sv
// rtl/bitser.sv - bit-plane serializer, N lanes of up-to-B-bit operands, MSB plane first
//
// Purpose: takes one parallel word of N lanes and emits its bit-planes one per cycle,
//   MSB first, with first/last/msb framing that drives a shift-accumulator downstream.
// Ports:
//   clk   clock, all logic on posedge
//   clr   synchronous active-high reset; discards active and pending words
//   bus   bitser_if.slave: word input stream and plane output stream
module bitser #(
    parameter int N  = 64,
    parameter int B  = 8,
    parameter int PW = 4
) (
    input  logic     clk,
    input  logic     clr,
    bitser_if.slave  bus
);
    localparam logic [PW-1:0] BMAX = PW'(B);

    // Active word: stored unshifted, cnt is the bit index currently on out_plane.
    logic [N*B-1:0] sr_data;
    logic [PW-1:0]  cnt;

    // One-deep pending slot, filled while the active word is still being emitted.
    logic [N*B-1:0] pend_data;
    logic [PW-1:0]  pend_p;
    logic           pend_sgn;
    logic           pend_full;

    logic           out_valid_r;
    logic [N-1:0]   out_plane_r;
    logic           out_first_r;
    logic           out_last_r;
    logic           out_msb_r;

    logic           in_ready_c;
    logic           accept;
    logic           sr_free;
    logic           advance;
    logic           ld_en;
    logic [N*B-1:0] ld_data;
    logic [PW-1:0]  ld_p;
    logic           ld_sgn;
    logic [PW-1:0]  ld_idx;
    logic [PW-1:0]  adv_idx;
    logic [PW-1:0]  in_p;

    function automatic logic [PW-1:0] clamp_prec(input logic [PW-1:0] p);
        if (p == '0)
            return PW'(1);
        else if (p > BMAX)
            return BMAX;
        else
            return p;
    endfunction

    // Gather bit idx of every lane into one plane.
    function automatic logic [N-1:0] plane_at(input logic [N*B-1:0] d, input logic [PW-1:0] idx);
        logic [N-1:0] pl;
        logic [B-1:0] lane;
        pl = '0;
        for (int i = 0; i < N; i++) begin
            lane  = d[i*B +: B] >> idx;
            pl[i] = lane[0];
        end
        return pl;
    endfunction

    always_comb begin
        // in_ready depends only on registered state and clr, never on out_ready.
        in_ready_c = !pend_full && !clr;
        accept     = bus.in_valid && in_ready_c;
        sr_free    = !out_valid_r || (bus.out_ready && out_last_r);
        advance    = out_valid_r && bus.out_ready && !out_last_r;
        in_p       = clamp_prec(bus.in_prec);
        // Pending word always wins over a new one; a new word goes straight
        // into SR when nothing is pending, which gives one-cycle latency.
        ld_data    = pend_full ? pend_data : bus.in_data;
        ld_p       = pend_full ? pend_p    : in_p;
        ld_sgn     = pend_full ? pend_sgn  : bus.in_sgn;
        ld_en      = sr_free && (pend_full || accept);
        ld_idx     = ld_p - PW'(1);
        adv_idx    = cnt - PW'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid_r <= 1'b0;
            out_plane_r <= '0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_msb_r   <= 1'b0;
            pend_full   <= 1'b0;
        end else if (sr_free) begin
            if (ld_en) begin
                sr_data     <= ld_data;
                cnt         <= ld_idx;
                out_plane_r <= plane_at(ld_data, ld_idx);
                out_first_r <= 1'b1;
                out_last_r  <= (ld_idx == '0);
                out_msb_r   <= ld_sgn;
                out_valid_r <= 1'b1;
                pend_full   <= 1'b0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            if (accept) begin
                pend_data <= bus.in_data;
                pend_p    <= in_p;
                pend_sgn  <= bus.in_sgn;
                pend_full <= 1'b1;
            end
            if (advance) begin
                cnt         <= adv_idx;
                out_plane_r <= plane_at(sr_data, adv_idx);
                out_first_r <= 1'b0;
                out_msb_r   <= 1'b0;
                out_last_r  <= (adv_idx == '0);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_plane = out_plane_r;
    assign bus.out_first = out_first_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_msb   = out_msb_r;
endmodule

// File: tb/tb_bitser.sv
// tb/tb_bitser.sv - directed self-checking bench for bitser (N=4, B=4)
module tb_bitser;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int PW = 4;

    logic clk;
    logic clr;

    bitser_if #(.N(N), .B(B), .PW(PW)) bus ();

    bitser #(.N(N), .B(B), .PW(PW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int total;
    int passed;
    int acc [N];
    int n_planes;
    int msb_cnt;
    int msb_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] pl,
                           input logic f, input logic l, input logic m);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_plane"}, 32'(bus.out_plane), 32'(pl));
        check({tag, "_flm"}, 32'({bus.out_first, bus.out_last, bus.out_msb}), 32'({f, l, m}));
    endtask

    task automatic offer(input logic [15:0] d, input logic [PW-1:0] p, input logic s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_prec  = p;
        bus.in_sgn   = s;
    endtask

    // Consume planes with out_ready=1 and rebuild lane values as shacc would.
    task automatic drain();
        logic done;
        int   v;
        done      = 1'b0;
        n_planes  = 0;
        msb_cnt   = 0;
        msb_first = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) begin
                n_planes++;
                if (bus.out_msb) begin
                    msb_cnt++;
                    if (bus.out_first) msb_first = 1;
                end
                for (int i = 0; i < N; i++) begin
                    v = bus.out_plane[i] ? 1 : 0;
                    if (bus.out_msb) v = -v;
                    acc[i] = bus.out_first ? v : acc[i] * 2 + v;
                end
                if (bus.out_last) done = 1'b1;
            end
            step();
            if (done) break;
        end
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        clr           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_prec   = '0;
        bus.in_sgn    = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_plane", 32'(bus.out_plane), 32'd0);
        check("rst_flm", 32'({bus.out_first, bus.out_last, bus.out_msb}), 32'd0);
        clr = 1'b0;
        #1;
        check("rst_in_ready_after", 32'(bus.in_ready), 32'd1);

        // T1: single unsigned word, prec 4
        offer(16'h0F5A, 4'd4, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk_out("t1_p0", 4'b0101, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("t1_p1", 4'b0110, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t1_p2", 4'b0101, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t1_p3", 4'b0110, 1'b0, 1'b1, 1'b0);
        step();
        check("t1_idle", 32'(bus.out_valid), 32'd0);

        // T2: two prec-3 words back to back, no bubble
        offer(16'h7531, 4'd3, 1'b0);
        step();
        offer(16'h2460, 4'd3, 1'b0);
        chk_out("t2_a0", 4'b1100, 1'b1, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk_out("t2_a1", 4'b1010, 1'b0, 1'b0, 1'b0);
        check("t2_ready_pend", 32'(bus.in_ready), 32'd0);
        step();
        chk_out("t2_a2", 4'b1111, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("t2_b0", 4'b0110, 1'b1, 1'b0, 1'b0);
        check("t2_ready_free", 32'(bus.in_ready), 32'd1);
        step();
        chk_out("t2_b1", 4'b1010, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t2_b2", 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        check("t2_idle", 32'(bus.out_valid), 32'd0);

        // T3: backpressure on plane 1 with a third word offered
        offer(16'h0F5A, 4'd4, 1'b0);
        step();
        offer(16'h1234, 4'd4, 1'b0);
        chk_out("t3_w1p0", 4'b0101, 1'b1, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        offer(16'hCF6D, 4'd2, 1'b0);
        chk_out("t3_hold0", 4'b0110, 1'b0, 1'b0, 1'b0);
        check("t3_ready0", 32'(bus.in_ready), 32'd0);
        step();
        chk_out("t3_hold1", 4'b0110, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t3_hold2", 4'b0110, 1'b0, 1'b0, 1'b0);
        check("t3_ready2", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk_out("t3_w1p2", 4'b0101, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t3_w1p3", 4'b0110, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("t3_w2p0", 4'b0000, 1'b1, 1'b0, 1'b0);
        check("t3_ready_w3", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk_out("t3_w2p1", 4'b0001, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t3_w2p2", 4'b0110, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t3_w2p3", 4'b1010, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("t3_w3p0", 4'b0110, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("t3_w3p1", 4'b0101, 1'b0, 1'b1, 1'b0);
        step();
        check("t3_idle", 32'(bus.out_valid), 32'd0);

        // T4: continuous prec-1 words, one plane per cycle
        offer(16'h4321, 4'd1, 1'b0);
        step();
        offer(16'h1234, 4'd1, 1'b0);
        chk_out("t4_w0", 4'b0101, 1'b1, 1'b1, 1'b0);
        check("t4_ready0", 32'(bus.in_ready), 32'd1);
        step();
        offer(16'h3333, 4'd1, 1'b0);
        chk_out("t4_w1", 4'b1010, 1'b1, 1'b1, 1'b0);
        step();
        offer(16'h2222, 4'd1, 1'b0);
        chk_out("t4_w2", 4'b1111, 1'b1, 1'b1, 1'b0);
        check("t4_ready2", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk_out("t4_w3", 4'b0000, 1'b1, 1'b1, 1'b0);
        step();
        check("t4_idle", 32'(bus.out_valid), 32'd0);

        // T5: precision clamps
        offer(16'h0F5A, 4'd0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        drain();
        check("t5_p0_planes", 32'(n_planes), 32'd1);
        check("t5_p0_lane1", 32'(acc[1]), 32'd1);
        check("t5_p0_lane0", 32'(acc[0]), 32'd0);
        offer(16'h0F5A, 4'd7, 1'b0);
        step();
        bus.in_valid = 1'b0;
        drain();
        check("t5_p7_planes", 32'(n_planes), 32'd4);
        check("t5_p7_lane0", 32'(acc[0]), 32'd10);
        check("t5_p7_lane2", 32'(acc[2]), 32'd15);
        check("t5_idle", 32'(bus.out_valid), 32'd0);

        // T6: signed word, lanes {-3, 7, -8, 0}
        offer(16'h087D, 4'd4, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk_out("t6_p0", 4'b0101, 1'b1, 1'b0, 1'b1);
        drain();
        check("t6_planes", 32'(n_planes), 32'd4);
        check("t6_msb_cnt", 32'(msb_cnt), 32'd1);
        check("t6_msb_first", 32'(msb_first), 32'd1);
        check("t6_lane0", 32'(acc[0]), 32'hFFFF_FFFD);
        check("t6_lane1", 32'(acc[1]), 32'd7);
        check("t6_lane2", 32'(acc[2]), 32'hFFFF_FFF8);
        check("t6_lane3", 32'(acc[3]), 32'd0);

        // T7: clr mid-word with the pending slot full
        offer(16'h0F5A, 4'd4, 1'b0);
        step();
        offer(16'h1234, 4'd4, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check("t7_pend_full", 32'(bus.in_ready), 32'd0);
        clr = 1'b1;
        #1;
        check("t7_ready_in_clr", 32'(bus.in_ready), 32'd0);
        step();
        check("t7_valid_clr", 32'(bus.out_valid), 32'd0);
        check("t7_plane_clr", 32'(bus.out_plane), 32'd0);
        clr = 1'b0;
        #1;
        check("t7_ready_after", 32'(bus.in_ready), 32'd1);
        step();
        check("t7_no_reappear0", 32'(bus.out_valid), 32'd0);
        step();
        check("t7_no_reappear1", 32'(bus.out_valid), 32'd0);
        offer(16'hCF6D, 4'd2, 1'b0);
        step();
        bus.in_valid = 1'b0;
        drain();
        check("t7_new_planes", 32'(n_planes), 32'd2);
        check("t7_new_lane0", 32'(acc[0]), 32'd1);
        check("t7_new_lane1", 32'(acc[1]), 32'd2);
        check("t7_new_lane2", 32'(acc[2]), 32'd3);
        check("t7_new_lane3", 32'(acc[3]), 32'd0);
        check("t7_idle", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
